// File: rtl/reg_loader_if.sv
// Byte-stream input plus register-file write/read port of the register loader.
// Read port signals exist only when REG_LOADER_VERIFY_EN is defined.
interface reg_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        write_register;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
`ifdef REG_LOADER_VERIFY_EN
  logic [1:0]        read_register;
  logic [DATA_W-1:0] read_data;

  modport master (
    input  in_data, in_valid, read_data,
    output in_ready, write_register, write_data, reg_write, read_register
  );
  modport slave (
    output in_data, in_valid, read_data,
    input  in_ready, write_register, write_data, reg_write, read_register
  );
`else
  modport master (
    input  in_data, in_valid,
    output in_ready, write_register, write_data, reg_write
  );
  modport slave (
    output in_data, in_valid,
    input  in_ready, write_register, write_data, reg_write
  );
`endif
endinterface

// File: rtl/reg_loader.sv
// Loads NUM_REGS bytes from a valid/ready stream into a register file, one write per byte.
// Readback verification of the loaded registers is compiled in with REG_LOADER_VERIFY_EN.
module reg_loader #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  reg_loader_if.master  bus,
  output logic          busy,
  output logic          done,
  output logic          error
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | accepting bytes, one register write per accepted byte
  // VERIFY | reading each register back against its shadow copy
  // DONE   | single-cycle end-of-sequence pulse
`ifdef REG_LOADER_VERIFY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, VERIFY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
`endif

  localparam logic [1:0] LAST_IDX = 2'(NUM_REGS - 1);

  state_t            state, state_nx;
  logic [1:0]        idx, idx_nx;
  logic              accept;
  logic              reg_write_nx;
  logic [1:0]        wr_reg_nx;
  logic [DATA_W-1:0] wr_data_nx;

  assign bus.in_ready = (state == LOAD);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign accept       = bus.in_valid && (state == LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      idx                <= 2'd0;
      bus.reg_write      <= 1'b0;
      bus.write_register <= 2'd0;
      bus.write_data     <= '0;
    end else begin
      state              <= state_nx;
      idx                <= idx_nx;
      bus.reg_write      <= reg_write_nx;
      bus.write_register <= wr_reg_nx;
      bus.write_data     <= wr_data_nx;
    end
  end

  // Write port is registered: the write for a byte appears the cycle after its accept.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    reg_write_nx = 1'b0;
    wr_reg_nx    = bus.write_register;
    wr_data_nx   = bus.write_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          idx_nx   = 2'd0;
        end
      end
      LOAD: begin
        if (accept) begin
          reg_write_nx = 1'b1;
          wr_reg_nx    = idx;
          wr_data_nx   = bus.in_data;
          if (idx == LAST_IDX) begin
            idx_nx = 2'd0;
`ifdef REG_LOADER_VERIFY_EN
            state_nx = VERIFY;
`else
            state_nx = DONE;
`endif
          end else begin
            idx_nx = idx + 2'd1;
          end
        end
      end
`ifdef REG_LOADER_VERIFY_EN
      VERIFY: begin
        if (idx == LAST_IDX) begin
          idx_nx   = 2'd0;
          state_nx = DONE;
        end else begin
          idx_nx = idx + 2'd1;
        end
      end
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef REG_LOADER_VERIFY_EN
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic              mismatch;

  assign bus.read_register = idx;
  assign mismatch = (state == VERIFY) && (bus.read_data != shadow[idx[IDX_W-1:0]]);

  always_ff @(posedge clk) begin
    if (accept) shadow[idx[IDX_W-1:0]] <= bus.in_data;
  end

  // Sticky until the next accepted start or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (state == IDLE && start) begin
      error <= 1'b0;
    end else if (mismatch) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_reg_loader.sv
// Scoreboard bench for reg_loader: a 4-register and a 1-register instance driven by random
// and directed byte sequences, writes and done pulses checked against a sequence-level model.
module tb_reg_loader;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic start4, start1;
  logic busy4, done4, error4;
  logic busy1, done1, error1;

  reg_loader_if #(.DATA_W(DW)) bus4 ();
  reg_loader_if #(.DATA_W(DW)) bus1 ();

  reg_loader #(.NUM_REGS(4), .DATA_W(DW)) u4 (
    .clk(clk), .reset(reset), .start(start4), .bus(bus4),
    .busy(busy4), .done(done4), .error(error4)
  );
  reg_loader #(.NUM_REGS(1), .DATA_W(DW)) u1 (
    .clk(clk), .reset(reset), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .error(error1)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf4 [4];
  logic [DW-1:0] rf1 [4];
  logic [DW-1:0] model_rf4 [4];
  logic [DW-1:0] seq_bytes [4];
  bit            corrupt;

  always @(posedge clk) begin
    if (bus4.reg_write) rf4[bus4.write_register] <= bus4.write_data;
    if (bus1.reg_write) rf1[bus1.write_register] <= bus1.write_data;
  end

`ifdef REG_LOADER_VERIFY_EN
  assign bus4.read_data = (corrupt && bus4.read_register == 2'd1) ? '0 : rf4[bus4.read_register];
  assign bus1.read_data = rf1[bus1.read_register];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt4, done_cnt1;
  wr_t exp4[$];
  wr_t exp1[$];
  bit  exp_done4[$];
  bit  exp_done1[$];
  int  wr_cyc4[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: every write and every done pulse must match the next expected item.
  always @(negedge clk) begin : mon4
    wr_t e;
    bit  de;
    if (bus4.reg_write === 1'b1) begin
      wr_cyc4.push_back(cyc);
      check("wr4_busy", 32'(busy4), 32'd1);
      if (exp4.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr4_unexpected actual addr=%0d data=%0h required no write",
                 bus4.write_register, bus4.write_data);
      end else begin
        e = exp4.pop_front();
        check("wr4_addr", 32'(bus4.write_register), 32'(e.addr));
        check("wr4_data", 32'(bus4.write_data), 32'(e.data));
      end
    end
    if (done4 === 1'b1) begin
      done_cnt4++;
      if (exp_done4.size() == 0) begin
        checks++; errors++;
        $display("FAIL done4_unexpected actual=1 required=0");
      end else begin
        de = exp_done4.pop_front();
        check("done4_error", 32'(error4), 32'(de));
      end
    end
  end

  always @(negedge clk) begin : mon1
    wr_t e;
    bit  de;
    if (bus1.reg_write === 1'b1) begin
      if (exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr1_unexpected actual addr=%0d data=%0h required no write",
                 bus1.write_register, bus1.write_data);
      end else begin
        e = exp1.pop_front();
        check("wr1_addr", 32'(bus1.write_register), 32'(e.addr));
        check("wr1_data", 32'(bus1.write_data), 32'(e.data));
      end
    end
    if (done1 === 1'b1) begin
      done_cnt1++;
      if (exp_done1.size() == 0) begin
        checks++; errors++;
        $display("FAIL done1_unexpected actual=1 required=0");
      end else begin
        de = exp_done1.pop_front();
        check("done1_error", 32'(error1), 32'(de));
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus4.in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy4), 32'd0);
    check({tag, "_done"}, 32'(done4), 32'd0);
    check({tag, "_reg_write"}, 32'(bus4.reg_write), 32'd0);
    check({tag, "_write_register"}, 32'(bus4.write_register), 32'd0);
    check({tag, "_write_data"}, 32'(bus4.write_data), 32'd0);
    check({tag, "_error"}, 32'(error4), 32'd0);
  endtask

  // gap < 0: random 0..2 idle cycles before each byte; abort_after > 0: reset after that many bytes.
  task automatic run_seq(input int gap, input bit start_mid, input bit start_in_done,
                         input int abort_after);
    int  n;
    int  g;
    int  guard;
    bit  exp_err;
    n = (abort_after > 0) ? abort_after : 4;
    exp_err = 1'b0;
`ifdef REG_LOADER_VERIFY_EN
    exp_err = corrupt && (seq_bytes[1] != 8'h00);
`endif
    for (int i = 0; i < n; i++) begin
      exp4.push_back('{addr: 2'(i), data: seq_bytes[i]});
      model_rf4[i] = seq_bytes[i];
    end
    if (abort_after == 0) exp_done4.push_back(exp_err);
    done_cnt4 = 0;
    wr_cyc4.delete();

    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      bus4.in_valid = 1'b0;
      repeat (g) begin
        @(negedge clk);
        check("gap_busy", 32'(busy4), 32'd1);
        check("gap_in_ready", 32'(bus4.in_ready), 32'd1);
        @(posedge clk); #1;
      end
      bus4.in_valid = 1'b1;
      bus4.in_data  = seq_bytes[i];
      if (start_mid && i == 1) start4 = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (bus4.in_ready !== 1'b1 && guard < 20);
      check("accept_ready", 32'(bus4.in_ready), 32'd1);
      @(posedge clk); #1;
      start4 = 1'b0;
    end
    bus4.in_valid = 1'b0;

    if (abort_after > 0) begin
      @(posedge clk); #1 reset = 1'b1;
      #1 check_idle_outputs("abort");
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_pending_writes", 32'(exp4.size()), 32'd0);
      check("abort_done_cnt", 32'(done_cnt4), 32'd0);
    end else begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (done4 !== 1'b1 && guard < 20);
      check("done_seen", 32'(done4), 32'd1);
      if (start_in_done) begin
        start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", 32'(busy4), 32'd0);
      end
      repeat (3) @(negedge clk);
      check("done_cnt", 32'(done_cnt4), 32'd1);
      check("pending_writes", 32'(exp4.size()), 32'd0);
      if (gap == 0) begin
        check("b2b_count", 32'(wr_cyc4.size()), 32'd4);
        if (wr_cyc4.size() == 4) check("b2b_span", 32'(wr_cyc4[3] - wr_cyc4[0]), 32'd3);
      end
    end
    for (int r = 0; r < 4; r++) check($sformatf("rf4_%0d", r), 32'(rf4[r]), 32'(model_rf4[r]));
  endtask

  initial begin
    bit err1;
    int guard;
    reset = 1'b1;
    start4 = 1'b0; start1 = 1'b0; corrupt = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0;
    bus1.in_valid = 1'b0; bus1.in_data = '0;
    for (int r = 0; r < 4; r++) begin
      rf4[r] = '0; rf1[r] = '0; model_rf4[r] = '0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_busy1", 32'(busy1), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    seq_bytes[0] = 8'h11; seq_bytes[1] = 8'h22; seq_bytes[2] = 8'h33; seq_bytes[3] = 8'h44;
    run_seq(0, 1'b0, 1'b0, 0);

    seq_bytes[0] = 8'hA5; seq_bytes[1] = 8'h5A; seq_bytes[2] = 8'hFF; seq_bytes[3] = 8'h00;
    run_seq(2, 1'b0, 1'b0, 0);

    for (int i = 0; i < 4; i++) seq_bytes[i] = 8'($urandom);
    run_seq(-1, 1'b1, 1'b1, 0);

    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 4; i++) seq_bytes[i] = 8'($urandom);
      run_seq(-1, 1'b0, s[0], 0);
    end

    seq_bytes[0] = 8'h01; seq_bytes[1] = 8'h02; seq_bytes[2] = 8'h03; seq_bytes[3] = 8'h04;
    run_seq(0, 1'b0, 1'b0, 2);

    for (int i = 0; i < 4; i++) seq_bytes[i] = 8'($urandom);
    run_seq(-1, 1'b0, 1'b0, 0);

`ifdef REG_LOADER_VERIFY_EN
    corrupt = 1'b1;
    seq_bytes[0] = 8'h10; seq_bytes[1] = 8'h11; seq_bytes[2] = 8'h12; seq_bytes[3] = 8'h13;
    run_seq(0, 1'b0, 1'b0, 0);
    corrupt = 1'b0;
    run_seq(-1, 1'b0, 1'b0, 0);
`endif

    // Single-register instance: one write, then no further accepts even with valid held.
    err1 = 1'b0;
`ifdef REG_LOADER_VERIFY_EN
    err1 = (rf1[0] != 8'h7E);
`endif
    exp1.push_back('{addr: 2'd0, data: 8'h7E});
    exp_done1.push_back(err1);
    done_cnt1 = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_data = 8'h7E;
    @(negedge clk);
    check("n1_in_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1 bus1.in_data = 8'h99;
    @(negedge clk);
    check("n1_in_ready_after_accept", 32'(bus1.in_ready), 32'd0);
    guard = 0;
    while (done1 !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("n1_done_seen", 32'(done1), 32'd1);
    bus1.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("n1_done_cnt", 32'(done_cnt1), 32'd1);
    check("n1_pending_writes", 32'(exp1.size()), 32'd0);
    check("n1_rf0", 32'(rf1[0]), 32'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
